// File: rtl/pc_jump_unit.sv
// Program counter and jump resolution unit for a four-phase instruction sequencer.
// It tracks FETCH/DECODE/EXECUTE/COMMIT, evaluates conditional jumps against registered flags and handles HALT.
module pc_jump_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_i,
  input  logic        decode_i,
  input  logic        execute_i,
  input  logic        commit_i,
  input  logic        pc_en_i,
  input  logic        jmp_x_i,
  input  logic        jrx_i,
  input  logic        cc_apply_x_i,
  input  logic        cc_invert_x_i,
  input  logic [1:0]  cc_select_x_i,
  input  logic [15:0] jump_operand_i,
  input  logic        flags_load_i,
  input  logic [3:0]  flags_i,
  output logic [15:0] pc_o,
  output logic [3:0]  flags_o,
  output logic        jump_taken_o,
  output logic        halted_o,
  output logic        seq_err_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCHED  = 3'd1,
    DECODED  = 3'd2,
    EXECUTED = 3'd3,
    HALT     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] target_q, target_d;
  logic [3:0]  flags_q, flags_d;
  logic        take_q, take_d;
  logic        halt_q, halt_d;
  logic        jump_taken_q, jump_taken_d;
  logic        seq_err_q, seq_err_d;
  // Set by the first FETCH after reset; a bare DECODE from IDLE is only legal once a fetch has happened.
  logic        primed_q, primed_d;

  logic [3:0]  strobes;
  logic        any_strobe;
  logic        single_strobe;
  logic        cond;
  logic [15:0] pc_inc;

  assign strobes       = {commit_i, execute_i, decode_i, fetch_i};
  assign any_strobe    = |strobes;
  assign single_strobe = any_strobe && ((strobes & (strobes - 4'd1)) == 4'd0);
  // Flags are {V,S,C,Z}, so the select value indexes the register directly.
  assign cond          = flags_q[cc_select_x_i] ^ cc_invert_x_i;
  assign pc_inc        = pc_q + 16'd2;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    target_d     = target_q;
    flags_d      = flags_q;
    take_d       = take_q;
    halt_d       = halt_q;
    jump_taken_d = 1'b0;
    seq_err_d    = seq_err_q;
    primed_d     = primed_q;

    case (state_q)
      IDLE: begin
        if (single_strobe && fetch_i) begin
          state_d  = FETCHED;
          pc_d     = {pc_inc[15:1], 1'b0};
          primed_d = 1'b1;
        end else if (single_strobe && decode_i && primed_q) begin
          state_d = DECODED;
          halt_d  = ~pc_en_i;
        end else if (any_strobe) begin
          seq_err_d = 1'b1;
        end
      end
      FETCHED: begin
        if (single_strobe && decode_i) begin
          state_d = DECODED;
          halt_d  = ~pc_en_i;
        end else if (any_strobe) begin
          seq_err_d = 1'b1;
        end
      end
      DECODED: begin
        if (single_strobe && execute_i) begin
          state_d  = EXECUTED;
          take_d   = jmp_x_i | (cc_apply_x_i & cond);
          target_d = jrx_i ? (pc_q + jump_operand_i) : jump_operand_i;
        end else if (any_strobe) begin
          seq_err_d = 1'b1;
        end
      end
      EXECUTED: begin
        if (single_strobe && commit_i) begin
          if (flags_load_i) begin
            flags_d = flags_i;
          end
          if (halt_q) begin
            state_d = HALT;
          end else begin
            state_d      = IDLE;
            jump_taken_d = take_q;
            if (take_q) begin
              pc_d = {target_q[15:1], 1'b0};
            end
          end
        end else if (any_strobe) begin
          seq_err_d = 1'b1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pc_q         <= {RESET_VECTOR[15:1], 1'b0};
      target_q     <= 16'h0000;
      flags_q      <= 4'h0;
      take_q       <= 1'b0;
      halt_q       <= 1'b0;
      jump_taken_q <= 1'b0;
      seq_err_q    <= 1'b0;
      primed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      target_q     <= target_d;
      flags_q      <= flags_d;
      take_q       <= take_d;
      halt_q       <= halt_d;
      jump_taken_q <= jump_taken_d;
      seq_err_q    <= seq_err_d;
      primed_q     <= primed_d;
    end
  end

  assign pc_o         = pc_q;
  assign flags_o      = flags_q;
  assign jump_taken_o = jump_taken_q;
  assign halted_o     = (state_q == HALT);
  assign seq_err_o    = seq_err_q;

endmodule

// File: tb/tb_pc_jump_unit.sv
// Directed bench for pc_jump_unit: sequential flow, absolute/relative/conditional jumps,
// flag timing, halt, sequence errors and asynchronous reset, all against hand-computed values.
module tb_pc_jump_unit;

  localparam logic [3:0] S_F = 4'b0001;
  localparam logic [3:0] S_D = 4'b0010;
  localparam logic [3:0] S_E = 4'b0100;
  localparam logic [3:0] S_C = 4'b1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch = 1'b0, decode = 1'b0, execute = 1'b0, commit = 1'b0;
  logic        pc_en = 1'b1, jmp_x = 1'b0, jrx = 1'b0;
  logic        cc_apply = 1'b0, cc_invert = 1'b0;
  logic [1:0]  cc_select = 2'b00;
  logic [15:0] operand = 16'h0000;
  logic        flags_load = 1'b0;
  logic [3:0]  flags_in = 4'h0;
  logic [15:0] pc;
  logic [3:0]  flags;
  logic        jump_taken, halted, seq_err;

  int n_checks = 0;
  int n_errors = 0;

  pc_jump_unit #(.RESET_VECTOR(16'h0000)) dut (
    .clk_i(clk), .rst_i(rst),
    .fetch_i(fetch), .decode_i(decode), .execute_i(execute), .commit_i(commit),
    .pc_en_i(pc_en), .jmp_x_i(jmp_x), .jrx_i(jrx),
    .cc_apply_x_i(cc_apply), .cc_invert_x_i(cc_invert), .cc_select_x_i(cc_select),
    .jump_operand_i(operand), .flags_load_i(flags_load), .flags_i(flags_in),
    .pc_o(pc), .flags_o(flags), .jump_taken_o(jump_taken),
    .halted_o(halted), .seq_err_o(seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive a strobe pattern for exactly one clock, returning at the following falling edge.
  task automatic pulse(input logic [3:0] s);
    @(negedge clk);
    {commit, execute, decode, fetch} = s;
    @(negedge clk);
    {commit, execute, decode, fetch} = 4'b0000;
  endtask

  task automatic set_ops(input logic en, input logic jx, input logic rel, input logic ap,
                         input logic inv, input logic [1:0] sel, input logic [15:0] op,
                         input logic fl, input logic [3:0] fi);
    pc_en = en; jmp_x = jx; jrx = rel; cc_apply = ap; cc_invert = inv;
    cc_select = sel; operand = op; flags_load = fl; flags_in = fi;
  endtask

  task automatic instr();
    pulse(S_F); pulse(S_D); pulse(S_E); pulse(S_C);
    $display("instr: pc=%h flags=%h jt=%b halted=%b seq_err=%b", pc, flags, jump_taken, halted, seq_err);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_pc", pc, 16'h0000);
    check("rst_flags", {12'h0, flags}, 16'h0000);
    check("rst_jt", {15'h0, jump_taken}, 16'h0);
    check("rst_halted", {15'h0, halted}, 16'h0);
    check("rst_seq_err", {15'h0, seq_err}, 16'h0);

    // Straight-line flow
    set_ops(1, 0, 0, 0, 0, 2'b00, 16'h0000, 0, 4'h0);
    for (int i = 1; i <= 3; i++) begin
      instr();
      check("seq_pc", pc, 16'(2 * i));
      check("seq_jt", {15'h0, jump_taken}, 16'h0);
    end

    // Absolute jump to 000E so the next fetch lands on 0010
    set_ops(1, 1, 0, 0, 0, 2'b00, 16'h000E, 0, 4'h0);
    instr();
    check("abs0_pc", pc, 16'h000E);
    check("abs0_jt", {15'h0, jump_taken}, 16'h1);
    @(negedge clk);
    check("abs0_jt_pulse", {15'h0, jump_taken}, 16'h0);

    // Absolute jump with odd operand 1235 -> 1234
    set_ops(1, 1, 0, 0, 0, 2'b00, 16'h1235, 0, 4'h0);
    pulse(S_F);
    check("abs1_fetch_pc", pc, 16'h0010);
    pulse(S_D); pulse(S_E); pulse(S_C);
    check("abs1_pc", pc, 16'h1234);
    check("abs1_jt", {15'h0, jump_taken}, 16'h1);
    @(negedge clk);
    check("abs1_jt_pulse", {15'h0, jump_taken}, 16'h0);

    // ALU op loading Z=1, then JZ sees the new flags
    set_ops(1, 0, 0, 0, 0, 2'b00, 16'h0000, 1, 4'b0001);
    instr();
    check("alu_pc", pc, 16'h1236);
    check("alu_flags", {12'h0, flags}, 16'h0001);
    set_ops(1, 0, 0, 1, 0, 2'b00, 16'hFFFE, 0, 4'h0);
    instr();
    check("jz_pc", pc, 16'hFFFE);
    check("jz_jt", {15'h0, jump_taken}, 16'h1);

    // Relative conditional with PC wrap: FFFE -> 0000, +FFFC -> FFFC
    set_ops(1, 0, 1, 1, 0, 2'b00, 16'hFFFC, 0, 4'h0);
    pulse(S_F);
    check("wrap_fetch_pc", pc, 16'h0000);
    pulse(S_D); pulse(S_E); pulse(S_C);
    check("rel_pc", pc, 16'hFFFC);
    check("rel_jt", {15'h0, jump_taken}, 16'h1);
    set_ops(1, 0, 1, 1, 1, 2'b00, 16'hFFFC, 0, 4'h0);
    instr();
    check("rel_inv_pc", pc, 16'hFFFE);
    check("rel_inv_jt", {15'h0, jump_taken}, 16'h0);

    // JMP_X with a false condition still takes; flags load alongside the jump
    set_ops(1, 1, 0, 1, 0, 2'b01, 16'h3001, 1, 4'b1000);
    instr();
    check("both_pc", pc, 16'h3000);
    check("both_flags", {12'h0, flags}, 16'h0008);
    check("both_jt", {15'h0, jump_taken}, 16'h1);

    // JV relative: condition uses V=1 even though commit clears the flags
    set_ops(1, 0, 1, 1, 0, 2'b11, 16'h0010, 1, 4'b0000);
    instr();
    check("jv_pc", pc, 16'h3012);
    check("jv_flags", {12'h0, flags}, 16'h0000);
    set_ops(1, 0, 0, 1, 0, 2'b11, 16'h5000, 0, 4'h0);
    instr();
    check("jv_nt_pc", pc, 16'h3014);
    check("jv_nt_jt", {15'h0, jump_taken}, 16'h0);

    // Sequence errors
    set_ops(1, 0, 0, 0, 0, 2'b00, 16'h0000, 0, 4'h0);
    pulse(S_F | S_D);
    check("multi_pc", pc, 16'h3014);
    check("multi_err", {15'h0, seq_err}, 16'h1);
    pulse(S_F);
    check("err_fetch_pc", pc, 16'h3016);
    pulse(S_E);
    check("err_exec_pc", pc, 16'h3016);
    pulse(S_D); pulse(S_E); pulse(S_C);
    check("err_cont_pc", pc, 16'h3016);
    check("err_sticky", {15'h0, seq_err}, 16'h1);

    // Halt: PC_EN=0 in decode; the pending jump is ignored
    set_ops(0, 1, 0, 0, 0, 2'b00, 16'h4000, 0, 4'h0);
    instr();
    check("halt_pc", pc, 16'h3018);
    check("halt_flag", {15'h0, halted}, 16'h1);
    check("halt_jt", {15'h0, jump_taken}, 16'h0);
    set_ops(1, 0, 0, 0, 0, 2'b00, 16'h0000, 0, 4'h0);
    pulse(S_F);
    check("halt_frozen_pc", pc, 16'h3018);

    // Asynchronous reset between edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_pc", pc, 16'h0000);
    check("arst_halted", {15'h0, halted}, 16'h0);
    check("arst_seq_err", {15'h0, seq_err}, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // First accepted strobe after reset must be FETCH
    pulse(S_D);
    check("post_rst_dec_err", {15'h0, seq_err}, 16'h1);
    check("post_rst_dec_pc", pc, 16'h0000);
    do_reset();

    // Reset mid-instruction abandons the pending jump
    set_ops(1, 1, 0, 0, 0, 2'b00, 16'h5000, 0, 4'h0);
    pulse(S_F); pulse(S_D); pulse(S_E);
    do_reset();
    pulse(S_C);
    check("abandon_pc", pc, 16'h0000);
    check("abandon_jt", {15'h0, jump_taken}, 16'h0);
    check("abandon_err", {15'h0, seq_err}, 16'h1);
    pulse(S_F);
    check("abandon_fetch_pc", pc, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
